// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the calendar-clock counter chain: 1 Hz tick in RUN, field select,
// inc/dec strobes with auto-repeat and blink in SET. Optional idle exit: define SET_TIMEOUT_EN.
module clock_set_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000,
  parameter int BLINK_DIV   = 12500000,
  parameter int TIMEOUT     = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic       sec_tick,
  output logic [2:0] field_sel,
  output logic       set_active,
  output logic [5:0] incr,
  output logic [5:0] dcr,
  output logic       blink
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SEC   = 3'd1,
    ST_MIN   = 3'd2,
    ST_HOUR  = 3'd3,
    ST_DAY   = 3'd4,
    ST_MONTH = 3'd5,
    ST_YEAR  = 3'd6
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REPEAT_DLY + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RPT_PRE    = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_RATE);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t          state_reg, state_next;
  logic            s_mode_reg, s_up_reg, s_dn_reg;
  logic            p_mode_reg, p_up_reg, p_dn_reg;
  logic [PW-1:0]   presc_reg;
  logic [RW-1:0]   rpt_reg;
  logic [BW-1:0]   blink_cnt_reg;
  logic            ev_mode, ev_up, ev_dn, up_only, dn_only;
  logic            state_change, rpt_hit, do_up, do_dn, timeout_hit;
  logic [5:0]      field_hot;

  assign ev_mode = s_mode_reg & ~p_mode_reg;
  assign ev_up   = s_up_reg & ~p_up_reg;
  assign ev_dn   = s_dn_reg & ~p_dn_reg;
  assign up_only = s_up_reg & ~s_dn_reg;
  assign dn_only = s_dn_reg & ~s_up_reg;

`ifdef SET_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT);
  logic [IW-1:0] idle_reg;

  assign timeout_hit = (state_reg != ST_RUN) && (idle_reg == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_reg <= '0;
    end else if (state_reg == ST_RUN || state_change || s_mode_reg || s_up_reg || s_dn_reg) begin
      idle_reg <= '0;
    end else if (!timeout_hit) begin
      idle_reg <= idle_reg + 1'b1;
    end
  end
`else
  // Never true; keeps the parameter referenced when the idle counter is not built.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_next = state_reg;
    if (ev_mode) begin
      state_next = (state_reg == ST_YEAR) ? ST_RUN : state_t'(state_reg + 3'd1);
    end else if (timeout_hit) begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    case (state_reg)
      ST_SEC:   field_hot = 6'b000001;
      ST_MIN:   field_hot = 6'b000010;
      ST_HOUR:  field_hot = 6'b000100;
      ST_DAY:   field_hot = 6'b001000;
      ST_MONTH: field_hot = 6'b010000;
      ST_YEAR:  field_hot = 6'b100000;
      default:  field_hot = 6'b000000;
    endcase
  end

  // A state change swallows any up/dn activity in the same cycle.
  assign state_change = (state_next != state_reg);
  assign rpt_hit      = (rpt_reg == RPT_PRE);
  assign do_up = !state_change && (state_reg != ST_RUN) && up_only && (ev_up || rpt_hit);
  assign do_dn = !state_change && (state_reg != ST_RUN) && dn_only && (ev_dn || rpt_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      s_mode_reg    <= 1'b0;
      s_up_reg      <= 1'b0;
      s_dn_reg      <= 1'b0;
      p_mode_reg    <= 1'b0;
      p_up_reg      <= 1'b0;
      p_dn_reg      <= 1'b0;
      presc_reg     <= '0;
      rpt_reg       <= '0;
      blink_cnt_reg <= '0;
      sec_tick      <= 1'b0;
      incr          <= 6'b0;
      dcr           <= 6'b0;
      blink         <= 1'b0;
    end else begin
      s_mode_reg <= btn_mode;
      s_up_reg   <= btn_up;
      s_dn_reg   <= btn_dn;
      p_mode_reg <= s_mode_reg;
      p_up_reg   <= s_up_reg;
      p_dn_reg   <= s_dn_reg;
      state_reg  <= state_next;

      if (state_reg != ST_RUN || state_next != ST_RUN) begin
        presc_reg <= '0;
        sec_tick  <= 1'b0;
      end else begin
        sec_tick  <= (presc_reg == PRESC_LAST);
        presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
      end

      // Repeat counter measures how long a single button has been held since its press.
      if (state_change || state_reg == ST_RUN || !(up_only || dn_only) ||
          (up_only && ev_up) || (dn_only && ev_dn)) begin
        rpt_reg <= '0;
      end else if (rpt_hit) begin
        rpt_reg <= RPT_RELOAD;
      end else begin
        rpt_reg <= rpt_reg + 1'b1;
      end

      incr <= do_up ? field_hot : 6'b0;
      dcr  <= do_dn ? field_hot : 6'b0;

      if (state_change || do_up || do_dn || state_next == ST_RUN) begin
        blink         <= 1'b0;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink         <= ~blink;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign field_sel  = state_reg;
  assign set_active = (state_reg != ST_RUN);

endmodule
